// File: rtl/proc_pkg.sv
// Shared processor definitions: sequencer states, byte-lane types, control opcodes,
// and the lane helpers that the memory sequencer and its byte mux use.
package proc_pkg;

   localparam int NBYTES = 4;

   typedef logic [1:0] byte_idx_t;

   typedef enum logic [1:0] {
      SEQ_IDLE   = 2'd0,
      SEQ_XFER   = 2'd1,
      SEQ_COMMIT = 2'd2
   } seq_state_t;

   // Opcodes and states decoded by the multicycle control FSM.
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef enum logic [3:0] {
      C_FETCH, C_DECODE, C_MEMADR, C_LBRD, C_LBWR,
      C_SBWR, C_RTYPEEX, C_RTYPEWR, C_BEQEX, C_JEX
   } ctrl_state_t;

   // Lowest enabled lane at or above 'from'; bit 2 of the result flags "found".
   function automatic logic [2:0] find_lane(input logic [0:NBYTES-1] en,
                                            input logic [2:0]        from);
      find_lane = 3'b000;
      for (int i = NBYTES - 1; i >= 0; i--) begin
         if (en[i] && (i >= int'(from))) find_lane = {1'b1, byte_idx_t'(i)};
      end
   endfunction

   // Byte k of the word is replaced by byte k of src wherever mask[k] is set.
   function automatic logic [0:31] merge_lanes(input logic [0:31]        old_word,
                                               input logic [0:31]        src_word,
                                               input logic [0:NBYTES-1]  mask);
      merge_lanes = old_word;
      for (int k = 0; k < NBYTES; k++) begin
         if (mask[k]) merge_lanes[8*k +: 8] = src_word[8*k +: 8];
      end
   endfunction

endpackage

// File: rtl/byte_lane_mux.sv
// Byte-lane selector/merger on MSB-first 32-bit words (byte 0 = bits [0:7]).
module byte_lane_mux
   import proc_pkg::*;
(
   input  logic [0:31]        i_word,
   input  logic [1:0]         i_sel,
   output logic [7:0]         o_byte,
   input  logic [0:31]        i_src,
   input  logic [0:NBYTES-1]  i_mask,
   output logic [0:31]        o_merged
);

   assign o_byte   = i_word[{i_sel, 3'b000} +: 8];
   assign o_merged = merge_lanes(i_word, i_src, i_mask);

endmodule

// File: rtl/mem_byte_sequencer.sv
// Converts one-cycle memread/memwrite strobes from control into byte-serial req/ack
// bus transfers and assembles the result into instr or mdr.
module mem_byte_sequencer
   import proc_pkg::*;
#(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          memread,
   input  logic          memwrite,
   input  logic          iord,
   input  logic [0:3]    iwrite,
   input  logic [AW-1:0] pc,
   input  logic [AW-1:0] aluout,
   input  logic [0:31]   wdata,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   input  logic          mem_ack,
   input  logic [7:0]    mem_rdata,
   output logic [0:31]   instr,
   output logic [0:31]   mdr,
   output logic          busy,
   output logic          done
);

   seq_state_t            r_state, w_next_state;
   byte_idx_t             r_k, w_next_k;
   logic [AW-1:0]         r_base;
   logic                  r_mode;
   logic                  r_iord;
   logic [0:NBYTES-1]     r_en;
   logic [0:31]           r_shadow;
   logic [0:31]           r_instr;
   logic [0:31]           r_mdr;

   logic                  w_start;
   logic [0:NBYTES-1]     w_en_in;
   logic [2:0]            w_first_lane;
   logic [2:0]            w_next_lane;
   logic                  w_commit;
   logic [0:31]           w_mux_word;
   logic [0:31]           w_mux_src;
   logic [0:NBYTES-1]     w_mux_mask;
   logic [0:31]           w_merged;

   assign w_start      = memread | memwrite;
   assign w_en_in      = (memread & ~memwrite & ~iord) ? iwrite : 4'b1111;
   assign w_first_lane = find_lane(w_en_in, 3'd0);
   assign w_next_lane  = find_lane(r_en, {1'b0, r_k} + 3'd1);

   // The shadow carries store data during writes and gathers read bytes during
   // loads, so one mux serves the write lane, the shadow fill and the instr commit.
   assign w_commit   = (r_state == SEQ_COMMIT);
   assign w_mux_word = w_commit ? r_instr  : r_shadow;
   assign w_mux_src  = w_commit ? r_shadow : {NBYTES{mem_rdata}};
   assign w_mux_mask = w_commit ? r_en     : (4'b1000 >> r_k);

   byte_lane_mux u_lane_mux (
      .i_word   (w_mux_word),
      .i_sel    (r_k),
      .o_byte   (mem_wdata),
      .i_src    (w_mux_src),
      .i_mask   (w_mux_mask),
      .o_merged (w_merged)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= SEQ_IDLE;
         r_k     <= '0;
      end else begin
         r_state <= w_next_state;
         r_k     <= w_next_k;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      w_next_state = r_state;
      w_next_k     = r_k;
      mem_req      = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         SEQ_IDLE: begin
            busy = w_start;
            if (w_start) begin
               w_next_state = w_first_lane[2] ? SEQ_XFER : SEQ_COMMIT;
               w_next_k     = w_first_lane[1:0];
            end
         end
         SEQ_XFER: begin
            mem_req = 1'b1;
            busy    = 1'b1;
            if (mem_ack) begin
               if (w_next_lane[2]) w_next_k     = w_next_lane[1:0];
               else                w_next_state = SEQ_COMMIT;
            end
         end
         SEQ_COMMIT: begin
            done         = 1'b1;
            w_next_state = SEQ_IDLE;
         end
         default: w_next_state = SEQ_IDLE;
      endcase
   end

   // NOTE: every register here is small and architecturally visible, so all are reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_base   <= '0;
         r_mode   <= 1'b0;
         r_iord   <= 1'b0;
         r_en     <= '0;
         r_shadow <= '0;
         r_instr  <= '0;
         r_mdr    <= '0;
      end else begin
         case (r_state)
            SEQ_IDLE: begin
               if (w_start) begin
                  r_base   <= iord ? aluout : pc;
                  r_mode   <= memwrite;
                  r_iord   <= iord;
                  r_en     <= w_en_in;
                  r_shadow <= wdata;
               end
            end
            SEQ_XFER: begin
               if (mem_ack && !r_mode) r_shadow <= w_merged;
            end
            SEQ_COMMIT: begin
               if (!r_mode) begin
                  if (r_iord) r_mdr   <= r_shadow;
                  else        r_instr <= w_merged;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_we   = mem_req & r_mode;
   assign mem_addr = r_base + AW'(r_k);
   assign instr    = r_instr;
   assign mdr      = r_mdr;

endmodule
